// File: rtl/zet_wb_dpram.sv
// Two-port Wishbone word memory: port A is read-only fetch, port B is read/write
// with byte lanes. Each port has its own wait-state FSM and an address window check.

module zet_wb_dpram_port #(
  parameter int unsigned WAIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       in_range_i,
  output logic       ack_o,
  output logic       err_o,
  output logic       take_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       ack_q;
  logic       err_q;
  logic       go_resp;

  // go_resp marks the edge that enters RESP; the window check and the write use it.
  always_comb begin
    go_resp = 1'b0;
    case (state_q)
      S_IDLE:  go_resp = req_i && (WAIT_CNT == 4'd0);
      S_WAIT:  go_resp = req_i && (cnt_q == 4'd1);
      default: go_resp = 1'b0;
    endcase
  end

  assign take_o  = go_resp & in_range_i;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= go_resp & in_range_i;
      err_q <= go_resp & ~in_range_i;
      case (state_q)
        S_IDLE: begin
          if (go_resp) begin
            state_q <= S_RESP;
          end else if (req_i) begin
            state_q <= S_WAIT;
            cnt_q   <= WAIT_CNT;
          end
        end
        S_WAIT: begin
          if (!req_i || go_resp) begin
            state_q <= req_i ? S_RESP : S_IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

module zet_wb_dpram #(
  parameter int          AW     = 19,
  parameter int unsigned BASE   = 0,
  parameter int unsigned DEPTH  = 2 ** AW,
  parameter int unsigned A_WAIT = 0,
  parameter int unsigned B_WAIT = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW:1]   wba_adr_i,
  input  logic [1:0]    wba_sel_i,
  input  logic          wba_cyc_i,
  input  logic          wba_stb_i,
  output logic [15:0]   wba_dat_o,
  output logic          wba_ack_o,
  output logic          wba_err_o,
  input  logic [AW:1]   wbb_adr_i,
  input  logic [15:0]   wbb_dat_i,
  input  logic          wbb_we_i,
  input  logic [1:0]    wbb_sel_i,
  input  logic          wbb_cyc_i,
  input  logic          wbb_stb_i,
  output logic [15:0]   wbb_dat_o,
  output logic          wbb_ack_o,
  output logic          wbb_err_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0] mem_q [DEPTH];
  logic [15:0] a_dat_q, b_dat_q;
  logic [31:0] a_off, b_off;
  logic        a_in, b_in, a_take, b_take;
  logic [1:0]  a_state, b_state;
  logic        unused_sel;

  assign unused_sel = ^wba_sel_i;

  // Window is BASE .. BASE+DEPTH-1, computed in 32 bits so the top edge cannot wrap.
  assign a_off = 32'(wba_adr_i) - BASE;
  assign b_off = 32'(wbb_adr_i) - BASE;
  assign a_in  = (32'(wba_adr_i) >= BASE) && (a_off < DEPTH);
  assign b_in  = (32'(wbb_adr_i) >= BASE) && (b_off < DEPTH);

  zet_wb_dpram_port #(.WAIT(A_WAIT)) u_port_a (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (wba_cyc_i & wba_stb_i),
    .in_range_i (a_in),
    .ack_o      (wba_ack_o),
    .err_o      (wba_err_o),
    .take_o     (a_take),
    .state_o    (a_state)
  );

  zet_wb_dpram_port #(.WAIT(B_WAIT)) u_port_b (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (wbb_cyc_i & wbb_stb_i),
    .in_range_i (b_in),
    .ack_o      (wbb_ack_o),
    .err_o      (wbb_err_o),
    .take_o     (b_take),
    .state_o    (b_state)
  );

  always_ff @(posedge clk_i) begin
    if (b_take && wbb_we_i) begin
      if (wbb_sel_i[1]) mem_q[b_off[IW-1:0]][15:8] <= wbb_dat_i[15:8];
      if (wbb_sel_i[0]) mem_q[b_off[IW-1:0]][7:0]  <= wbb_dat_i[7:0];
    end
  end

  // Reads sample the array before this edge's write lands, so a same-edge
  // collision hands port A the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_dat_q <= 16'h0000;
      b_dat_q <= 16'h0000;
    end else begin
      if (a_take)              a_dat_q <= mem_q[a_off[IW-1:0]];
      if (b_take && !wbb_we_i) b_dat_q <= mem_q[b_off[IW-1:0]];
    end
  end

  assign wba_dat_o = a_dat_q;
  assign wbb_dat_o = b_dat_q;
endmodule

// File: tb/tb_zet_wb_dpram.sv
// Directed bench for zet_wb_dpram: four instances cover zero/non-zero wait states,
// an offset window, collisions and aborts by strobe drop or reset.

module tb_zet_wb_dpram;
  logic clk;
  logic rst_n;

  logic [18:0] a_adr [4];
  logic [1:0]  a_sel [4];
  logic        a_cyc [4];
  logic        a_stb [4];
  logic [15:0] a_dat [4];
  logic        a_ack [4];
  logic        a_err [4];
  logic [18:0] b_adr [4];
  logic [15:0] b_wdat [4];
  logic        b_we [4];
  logic [1:0]  b_sel [4];
  logic        b_cyc [4];
  logic        b_stb [4];
  logic [15:0] b_dat [4];
  logic        b_ack [4];
  logic        b_err [4];

  int compared = 0;
  int mism = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: no waits; 1: A_WAIT=1,B_WAIT=2; 2: window at 0x78000; 3: B_WAIT=3
  for (genvar g = 0; g < 4; g++) begin : g_dut
    zet_wb_dpram #(
      .AW     (19),
      .BASE   (g == 2 ? 32'h78000 : 32'h0),
      .DEPTH  (g == 2 ? 32'h8000 : 32'd1024),
      .A_WAIT (g == 1 ? 1 : 0),
      .B_WAIT (g == 1 ? 2 : (g == 3 ? 3 : 0))
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wba_adr_i (a_adr[g]),
      .wba_sel_i (a_sel[g]),
      .wba_cyc_i (a_cyc[g]),
      .wba_stb_i (a_stb[g]),
      .wba_dat_o (a_dat[g]),
      .wba_ack_o (a_ack[g]),
      .wba_err_o (a_err[g]),
      .wbb_adr_i (b_adr[g]),
      .wbb_dat_i (b_wdat[g]),
      .wbb_we_i  (b_we[g]),
      .wbb_sel_i (b_sel[g]),
      .wbb_cyc_i (b_cyc[g]),
      .wbb_stb_i (b_stb[g]),
      .wbb_dat_o (b_dat[g]),
      .wbb_ack_o (b_ack[g]),
      .wbb_err_o (b_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Port B transaction; lat counts edges from the request until ack/err (20 = timeout).
  task automatic b_xfer(input int u, input logic [18:0] adr, input logic [15:0] dat,
                        input logic we, input logic [1:0] sel,
                        output logic ack, output logic err, output logic [15:0] rd,
                        output int lat, output logic pst);
    @(posedge clk); #1;
    b_adr[u] = adr; b_wdat[u] = dat; b_we[u] = we; b_sel[u] = sel;
    b_cyc[u] = 1'b1; b_stb[u] = 1'b1;
    lat = 20;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_ack[u] || b_err[u]) begin
        lat = i;
        break;
      end
    end
    ack = b_ack[u]; err = b_err[u]; rd = b_dat[u];
    b_cyc[u] = 1'b0; b_stb[u] = 1'b0; b_we[u] = 1'b0;
    @(posedge clk); #1;
    pst = b_ack[u] | b_err[u];
  endtask

  task automatic a_xfer(input int u, input logic [18:0] adr,
                        output logic ack, output logic err, output logic [15:0] rd,
                        output int lat, output logic pst);
    @(posedge clk); #1;
    a_adr[u] = adr; a_sel[u] = 2'b11; a_cyc[u] = 1'b1; a_stb[u] = 1'b1;
    lat = 20;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      if (a_ack[u] || a_err[u]) begin
        lat = i;
        break;
      end
    end
    ack = a_ack[u]; err = a_err[u]; rd = a_dat[u];
    a_cyc[u] = 1'b0; a_stb[u] = 1'b0;
    @(posedge clk); #1;
    pst = a_ack[u] | a_err[u];
  endtask

  initial begin
    logic        ack, err, pst, seen;
    logic [15:0] rd;
    int          lat;

    for (int i = 0; i < 4; i++) begin
      a_adr[i] = '0; a_sel[i] = '0; a_cyc[i] = 1'b0; a_stb[i] = 1'b0;
      b_adr[i] = '0; b_wdat[i] = '0; b_we[i] = 1'b0; b_sel[i] = '0;
      b_cyc[i] = 1'b0; b_stb[i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    check("rst_u0_flags", {28'd0, a_ack[0], a_err[0], b_ack[0], b_err[0]}, 32'h0);
    check("rst_u0_dat", {a_dat[0], b_dat[0]}, 32'h0);
    #10 rst_n = 1'b1;

    // Zero-wait fetch of a preloaded word
    b_xfer(0, 19'h00100, 16'hBEEF, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u0_preload_lat", 32'(lat), 32'd1);
    a_xfer(0, 19'h00100, ack, err, rd, lat, pst);
    check("u0_a_lat", 32'(lat), 32'd1);
    check("u0_a_ack_err", {30'd0, ack, err}, 32'h2);
    check("u0_a_dat", {16'd0, rd}, 32'h0000BEEF);
    check("u0_a_one_cycle", {31'd0, pst}, 32'h0);

    // Two wait states on B, byte-lane write
    b_xfer(1, 19'h00040, 16'hAAAA, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u1_b_lat", 32'(lat), 32'd3);
    b_xfer(1, 19'h00040, 16'h1234, 1'b1, 2'b10, ack, err, rd, lat, pst);
    check("u1_b_sel10_lat", 32'(lat), 32'd3);
    check("u1_b_sel10_ack", {30'd0, ack, err}, 32'h2);
    b_xfer(1, 19'h00040, 16'h0000, 1'b0, 2'b00, ack, err, rd, lat, pst);
    check("u1_b_rd_12AA", {16'd0, rd}, 32'h000012AA);
    b_xfer(1, 19'h00040, 16'hFFFF, 1'b1, 2'b00, ack, err, rd, lat, pst);
    check("u1_b_sel00_ack", {30'd0, ack, err}, 32'h2);
    a_xfer(1, 19'h00040, ack, err, rd, lat, pst);
    check("u1_a_lat", 32'(lat), 32'd2);
    check("u1_a_sel00_nowrite", {16'd0, rd}, 32'h000012AA);

    // Offset window with error responses at both edges
    b_xfer(2, 19'h78010, 16'h5A5A, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u2_in_ack", {30'd0, ack, err}, 32'h2);
    b_xfer(2, 19'h78010, 16'h0000, 1'b0, 2'b11, ack, err, rd, lat, pst);
    check("u2_in_rd", {16'd0, rd}, 32'h00005A5A);
    b_xfer(2, 19'h00010, 16'hFFFF, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u2_out_err", {30'd0, ack, err}, 32'h1);
    check("u2_out_lat", 32'(lat), 32'd1);
    check("u2_err_one_cycle", {31'd0, pst}, 32'h0);
    b_xfer(2, 19'h77FFF, 16'h0000, 1'b0, 2'b11, ack, err, rd, lat, pst);
    check("u2_below_err", {30'd0, ack, err}, 32'h1);
    check("u2_err_dat_hold", {16'd0, rd}, 32'h00005A5A);
    b_xfer(2, 19'h7FFFF, 16'h1111, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u2_top_ack", {30'd0, ack, err}, 32'h2);
    a_xfer(2, 19'h7FFFF, ack, err, rd, lat, pst);
    check("u2_top_rd", {16'd0, rd}, 32'h00001111);
    a_xfer(2, 19'h78010, ack, err, rd, lat, pst);
    check("u2_unchanged", {16'd0, rd}, 32'h00005A5A);

    // Same-edge collision: A sees old word
    b_xfer(0, 19'h00200, 16'h0001, 1'b1, 2'b11, ack, err, rd, lat, pst);
    @(posedge clk); #1;
    a_adr[0] = 19'h00200; a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
    b_adr[0] = 19'h00200; b_wdat[0] = 16'h0002; b_we[0] = 1'b1; b_sel[0] = 2'b11;
    b_cyc[0] = 1'b1; b_stb[0] = 1'b1;
    @(posedge clk); #1;
    check("col_both_ack", {30'd0, a_ack[0], b_ack[0]}, 32'h3);
    check("col_a_old", {16'd0, a_dat[0]}, 32'h00000001);
    a_cyc[0] = 1'b0; a_stb[0] = 1'b0; b_cyc[0] = 1'b0; b_stb[0] = 1'b0; b_we[0] = 1'b0;
    a_xfer(0, 19'h00200, ack, err, rd, lat, pst);
    check("col_a_new", {16'd0, rd}, 32'h00000002);

    // Abort by dropping strobe in the second wait cycle
    b_xfer(3, 19'h00080, 16'hC3C3, 1'b1, 2'b11, ack, err, rd, lat, pst);
    check("u3_b_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    b_adr[3] = 19'h00080; b_wdat[3] = 16'hFFFF; b_we[3] = 1'b1; b_sel[3] = 2'b11;
    b_cyc[3] = 1'b1; b_stb[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_stb[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | b_ack[3] | b_err[3];
    end
    b_cyc[3] = 1'b0; b_we[3] = 1'b0;
    check("u3_abort_stb_quiet", {31'd0, seen}, 32'h0);
    b_xfer(3, 19'h00080, 16'h0000, 1'b0, 2'b11, ack, err, rd, lat, pst);
    check("u3_abort_stb_word", {16'd0, rd}, 32'h0000C3C3);

    // Same abort, cut short by reset
    @(posedge clk); #1;
    b_adr[3] = 19'h00080; b_wdat[3] = 16'h1234; b_we[3] = 1'b1; b_sel[3] = 2'b11;
    b_cyc[3] = 1'b1; b_stb[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    b_cyc[3] = 1'b0; b_stb[3] = 1'b0; b_we[3] = 1'b0;
    #2;
    check("rst_u3_flags", {28'd0, a_ack[3], a_err[3], b_ack[3], b_err[3]}, 32'h0);
    check("rst_u3_b_dat", {16'd0, b_dat[3]}, 32'h0);
    check("rst_u0_a_dat", {16'd0, a_dat[0]}, 32'h0);
    #10 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | b_ack[3] | b_err[3];
    end
    check("u3_abort_rst_quiet", {31'd0, seen}, 32'h0);
    b_xfer(3, 19'h00080, 16'h0000, 1'b0, 2'b11, ack, err, rd, lat, pst);
    check("u3_abort_rst_word", {16'd0, rd}, 32'h0000C3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/zet_wb_dpram.md
# zet_wb_dpram

Parametrised two-port Wishbone word memory for Zet simulation and FPGA builds: port A serves the instruction-fetch master (read-only), port B serves the data master (read/write, byte lanes). It adds what the previous two-port memory lacked: a configurable address window with an error response, independent programmable wait states per port, and a defined same-word collision rule. It sits between the core's fetch/data buses and on-chip RAM, behind the I/O decode (`tga`).

## Interface
- AW, 19: word-address MSB; addresses are `[AW:1]`.
- BASE, 0: first word index decoded by the block.
- DEPTH, 2**AW: number of 16-bit words; valid window is BASE .. BASE+DEPTH-1.
- A_WAIT, 0: extra wait cycles on port A (0..15).
- B_WAIT, 0: extra wait cycles on port B (0..15).

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- wba_adr_i  in  AW  fetch word address.
- wba_sel_i  in  2  byte lanes (ignored; full word returned).
- wba_cyc_i, wba_stb_i  in  1 each  fetch cycle/strobe.
- wba_dat_o  out  16  fetch read data.
- wba_ack_o  out  1  fetch acknowledge.
- wba_err_o  out  1  fetch address outside window.
- wbb_adr_i  in  AW  data word address.
- wbb_dat_i  in  16  write data.
- wbb_we_i  in  1  write enable.
- wbb_sel_i  in  2  byte lanes; bit1 = [15:8], bit0 = [7:0].
- wbb_cyc_i, wbb_stb_i  in  1 each  data cycle/strobe.
- wbb_dat_o  out  16  data read data.
- wbb_ack_o  out  1  data acknowledge.
- wbb_err_o  out  1  data address outside window.

## Operation
- Storage: DEPTH x 16 array; index = adr − BASE. No reset of contents; preload via `$readmemh` on the array.
- Each port has an independent FSM with states IDLE, WAIT, RESP:
  - IDLE: samples cyc&stb at an edge. With wait = 0 it goes to RESP; otherwise it loads the wait counter with the port's wait value and goes to WAIT.
  - WAIT: the counter decrements each cycle. At 1 it goes to RESP.
  - WAIT, master drops cyc or stb: return to IDLE with no ack, no err and no write (abort).
  - RESP: one cycle with ack or err high, then IDLE unconditionally. A request still held high is re-sampled in IDLE on the next edge as a new transaction.
- Window check uses the address at the edge entering RESP.
  - In range: ack=1, and the read data is registered on that edge.
  - Out of range: err=1, ack=0, no write, dat_o holds its previous value.
- Port B write commits on the edge entering RESP, only to lanes whose sel bit is 1. sel=00 still acks and writes nothing.
- Port B read returns the full word regardless of sel.
- Collision: port A reads a word on the same edge port B commits a write to it. Port A returns the old (pre-write) value; the array holds the new value. Port B read-after-write in consecutive transactions returns the new value.
- Masters hold address, data and we stable from request until ack/err, per Wishbone classic. Changes mid-WAIT are not supported; the last sampled value wins.

## Timing
- Reset (rst_ni=0, async): ack, err and dat_o of both ports = 0; both FSMs in IDLE; counters = 0. Asserting reset mid-WAIT drops the transaction and leaves no pending write.
- Latency: ack/err rises W+1 cycles after the edge that samples the request, where W is the port's wait value. With W=0, ack is high in the cycle after the request edge.
- Throughput per port: one transaction per W+2 cycles.
- The two ports never stall each other.
- ack and err are never high together, and each is high for exactly one cycle per transaction.

## Test plan
- Preload word 0x100 = 16'hBEEF, A_WAIT=0. Port A reads 0x100 → wba_ack_o high one cycle after the request edge, wba_dat_o=16'hBEEF.
- B_WAIT=2. Port B writes 16'h1234 with sel=10 to a word holding 16'hAAAA → ack 3 cycles after the request edge. Readback returns 16'h12AA.
- BASE=19'h78000, DEPTH=16'h8000. Port B accesses 19'h00010 → wbb_err_o pulses one cycle, no ack, memory unchanged. Access to 19'h78010 → ack.
- Collision: word holds 16'h0001. Port A reads and port B writes 16'h0002 to it, both acked on the same edge → wba_dat_o=16'h0001. Next port A read returns 16'h0002.
- B_WAIT=3. Drop wbb_stb_i in the second wait cycle of a write → no ack, no err, word unchanged.
- Repeat the same abort case with rst_ni asserted instead of dropping strobe → same required result; all outputs read 0 during reset.
